// File: rtl/display_bbox_feeder.sv
// Stages one detection result set and bursts MAX_BBOX display-space words (all-ones pads) per frame_sync, first word 4 cycles later.
// det_ready drops only while a burst is emitting; `DISPLAY_BBOX_SCALE_EN enables Q8 scaling, otherwise coordinates are only clamped.
module display_bbox_feeder #(
   parameter int MAX_BBOX     = 5,
   parameter int SRC_WIDTH    = 96,
   parameter int SRC_HEIGHT   = 96,
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        det_start,
   input  logic [63:0] det_data,
   input  logic        det_valid,
   input  logic        det_last,
   output logic        det_ready,
   input  logic        frame_sync,
   output logic [63:0] bbox_data_out,
   output logic        bbox_data_out_valid,
   output logic        overflow
);
   localparam int CW = $clog2(MAX_BBOX + 1);
   localparam int SCALE_X_Q8 = (FRAME_WIDTH * 256) / SRC_WIDTH;
   localparam int SCALE_Y_Q8 = (FRAME_HEIGHT * 256) / SRC_HEIGHT;
   localparam logic [15:0]   X_MAX   = 16'(FRAME_WIDTH - 1);
   localparam logic [15:0]   Y_MAX   = 16'(FRAME_HEIGHT - 1);
   localparam logic [CW-1:0] LAST_K  = CW'(MAX_BBOX - 1);
   localparam logic [CW-1:0] N_SLOTS = CW'(MAX_BBOX);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] k_q, k_d;
   logic          sync_q, sync_d;
   logic          pending_q, pending_d;
   logic [CW-1:0] scount_q, scount_d;
   logic [CW-1:0] pcount_q, pcount_d;
   logic          ovf_q, ovf_d;
   logic [63:0]   stage_q [MAX_BBOX];
   logic [63:0]   stage_d [MAX_BBOX];
   logic [63:0]   pend_q  [MAX_BBOX];
   logic [63:0]   pend_d  [MAX_BBOX];
   logic          s1_vld_q, s1_nobox_q;
   logic [15:0]   s1_c_q [4];
   logic [15:0]   s1_c_d [4];
   logic [63:0]   out_q;
   logic          out_vld_q;

   logic          accept, good, commit;
   logic [63:0]   slot;

   assign det_ready = (state_q != EMIT);
   assign accept    = det_valid & det_ready;
   assign good      = (det_data[63:48] <= det_data[31:16]) && (det_data[47:32] <= det_data[15:0]);

   // Ingest: det_start clears before the same-cycle record is stored; the
   // commit snapshot includes the record accepted alongside det_last.
   always_comb begin
      stage_d  = stage_q;
      pend_d   = pend_q;
      pcount_d = pcount_q;
      ovf_d    = det_start ? 1'b0 : ovf_q;
      scount_d = det_start ? '0 : scount_q;
      commit   = 1'b0;
      if (accept && good) begin
         if (scount_d < N_SLOTS) begin
            for (int i = 0; i < MAX_BBOX; i++) begin
               if (scount_d == CW'(i)) stage_d[i] = det_data;
            end
            scount_d = scount_d + CW'(1);
         end else begin
            ovf_d = 1'b1;
         end
      end
      if (accept && det_last) begin
         pend_d   = stage_d;
         pcount_d = scount_d;
         scount_d = '0;
         commit   = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      sync_d    = sync_q | frame_sync;
      pending_d = pending_q;
      case (state_q)
         IDLE: begin
            if (sync_q) begin
               sync_d = frame_sync;
               if (pending_q) begin
                  state_d   = EMIT;
                  k_d       = '0;
                  pending_d = 1'b0;
               end
            end
         end
         EMIT: begin
            k_d = k_q + CW'(1);
            if (k_q == LAST_K) begin
               state_d = IDLE;
               k_d     = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      // A commit landing as a burst starts keeps the new set pending.
      if (commit) pending_d = 1'b1;
   end

   always_comb begin
      slot = '1;
      for (int i = 0; i < MAX_BBOX; i++) begin
         if (k_q == CW'(i)) slot = pend_q[i];
      end
   end

`ifdef DISPLAY_BBOX_SCALE_EN
   localparam logic [31:0] SX = 32'(SCALE_X_Q8);
   localparam logic [31:0] SY = 32'(SCALE_Y_Q8);
   logic [31:0] prod [4];
   logic        unused_prod;
   always_comb begin
      prod[0] = {16'd0, slot[63:48]} * SX;
      prod[1] = {16'd0, slot[47:32]} * SY;
      prod[2] = {16'd0, slot[31:16]} * SX;
      prod[3] = {16'd0, slot[15:0]}  * SY;
      for (int i = 0; i < 4; i++) s1_c_d[i] = prod[i][23:8];
   end
   assign unused_prod = ^{prod[0][31:24], prod[0][7:0], prod[1][31:24], prod[1][7:0],
                          prod[2][31:24], prod[2][7:0], prod[3][31:24], prod[3][7:0]};
`else
   localparam int unused_scale = SCALE_X_Q8 ^ SCALE_Y_Q8;
   always_comb begin
      s1_c_d[0] = slot[63:48];
      s1_c_d[1] = slot[47:32];
      s1_c_d[2] = slot[31:16];
      s1_c_d[3] = slot[15:0];
   end
`endif

   function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] m);
      return (v > m) ? m : v;
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         k_q        <= '0;
         sync_q     <= 1'b0;
         pending_q  <= 1'b0;
         scount_q   <= '0;
         pcount_q   <= '0;
         ovf_q      <= 1'b0;
         for (int i = 0; i < MAX_BBOX; i++) begin
            stage_q[i] <= '0;
            pend_q[i]  <= '0;
         end
         s1_vld_q   <= 1'b0;
         s1_nobox_q <= 1'b0;
         for (int i = 0; i < 4; i++) s1_c_q[i] <= '0;
         out_q      <= '0;
         out_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         sync_q    <= sync_d;
         pending_q <= pending_d;
         scount_q  <= scount_d;
         pcount_q  <= pcount_d;
         ovf_q     <= ovf_d;
         stage_q   <= stage_d;
         pend_q    <= pend_d;
         s1_vld_q  <= (state_q == EMIT);
         if (state_q == EMIT) begin
            s1_nobox_q <= (k_q >= pcount_q);
            s1_c_q     <= s1_c_d;
         end
         out_vld_q <= s1_vld_q;
         // Pad words bypass the clamp so the drawer sees a true no-box marker.
         if (s1_vld_q) begin
            out_q <= s1_nobox_q ? {64{1'b1}} :
                     {clamp(s1_c_q[0], X_MAX), clamp(s1_c_q[1], Y_MAX),
                      clamp(s1_c_q[2], X_MAX), clamp(s1_c_q[3], Y_MAX)};
         end
      end
   end

   assign bbox_data_out       = out_q;
   assign bbox_data_out_valid = out_vld_q;
   assign overflow            = ovf_q;

endmodule

// File: tb/tb_display_bbox_feeder.sv
// Scoreboard bench for display_bbox_feeder: expected words are queued from a small model as stimulus is driven.
module tb_display_bbox_feeder;
   logic        clk = 1'b0, rstn = 1'b0;
   logic        det_start = 1'b0, det_valid = 1'b0, det_last = 1'b0, frame_sync = 1'b0;
   logic [63:0] det_data = '0;
   logic        det_ready, bbox_data_out_valid, overflow;
   logic [63:0] bbox_data_out;

   always #5 clk = ~clk;

   display_bbox_feeder dut (
      .clk(clk), .rstn(rstn), .det_start(det_start), .det_data(det_data),
      .det_valid(det_valid), .det_last(det_last), .det_ready(det_ready),
      .frame_sync(frame_sync), .bbox_data_out(bbox_data_out),
      .bbox_data_out_valid(bbox_data_out_valid), .overflow(overflow)
   );

   int n_pass = 0, n_total = 0;
   logic [63:0] exp_q[$];
   logic [63:0] got_q[$];
   logic [63:0] stage_m[$];
   logic [63:0] pend_m[$];
   bit pend_vld_m = 0, ovf_m = 0;
   int first_off, last_off, nvalid, rdy_low;

   function automatic logic [15:0] model_coord(input logic [15:0] c, input bit is_y);
      int unsigned v;
`ifdef DISPLAY_BBOX_SCALE_EN
      v = ((int'(c) * (is_y ? (480 * 256 / 96) : (640 * 256 / 96))) / 256) % 65536;
`else
      v = c;
`endif
      if (!is_y && v > 639) v = 639;
      if (is_y && v > 479) v = 479;
      return 16'(v);
   endfunction

   function automatic logic [63:0] model_box(input logic [63:0] d);
      return {model_coord(d[63:48], 0), model_coord(d[47:32], 1),
              model_coord(d[31:16], 0), model_coord(d[15:0], 1)};
   endfunction

   task automatic send_rec(input logic [63:0] d, input bit start, input bit last, input bit advance);
      det_data = d; det_valid = 1'b1; det_start = start; det_last = last;
      if (start) begin stage_m.delete(); ovf_m = 0; end
      if (d[63:48] <= d[31:16] && d[47:32] <= d[15:0]) begin
         if (stage_m.size() < 5) stage_m.push_back(model_box(d));
         else ovf_m = 1;
      end
      if (last) begin pend_m = stage_m; pend_vld_m = 1; stage_m.delete(); end
      if (advance) begin
         @(posedge clk); #1;
         det_valid = 1'b0; det_start = 1'b0; det_last = 1'b0;
      end
   endtask

   // Pulses frame_sync this cycle and records 20 cycles of output; n is the offset from the pulse.
   task automatic frame_capture();
      exp_q.delete();
      if (pend_vld_m) begin
         for (int i = 0; i < 5; i++) exp_q.push_back(i < pend_m.size() ? pend_m[i] : {64{1'b1}});
         pend_vld_m = 0;
      end
      got_q.delete(); first_off = -1; last_off = -1; nvalid = 0; rdy_low = 0;
      frame_sync = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bbox_data_out_valid) begin
            if (first_off < 0) first_off = n;
            last_off = n; nvalid++;
            got_q.push_back(bbox_data_out);
         end
         if (!det_ready) rdy_low++;
         @(posedge clk); #1;
         frame_sync = 1'b0; det_valid = 1'b0; det_last = 1'b0; det_start = 1'b0;
      end
   endtask

   task automatic test_reset();
      #2;
      n_total++; if (bbox_data_out_valid !== 1'b0) $display("FAIL rst_valid_in_reset: got %b want 0", bbox_data_out_valid); else n_pass++;
      n_total++; if (det_ready !== 1'b1) $display("FAIL rst_ready_in_reset: got %b want 1", det_ready); else n_pass++;
      repeat (3) @(posedge clk); #1; rstn = 1'b1;
      @(negedge clk);
      n_total++; if (bbox_data_out !== 64'd0) $display("FAIL rst_data: got %h want 0", bbox_data_out); else n_pass++;
      n_total++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else n_pass++;
      n_total++; if (bbox_data_out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bbox_data_out_valid); else n_pass++;
      @(posedge clk); #1;
   endtask

   task automatic test_no_commit();
      frame_capture();
      n_total++; if (nvalid != 0) $display("FAIL nocommit_valid: got %0d words want 0", nvalid); else n_pass++;
      n_total++; if (rdy_low != 0) $display("FAIL nocommit_ready: got %0d low cycles want 0", rdy_low); else n_pass++;
   endtask

   task automatic test_single();
      logic [63:0] e;
      send_rec({16'd0, 16'd0, 16'd95, 16'd95}, 1, 1, 1);
      frame_capture();
      n_total++; if (first_off != 4) $display("FAIL single_first: got T+%0d want T+4", first_off); else n_pass++;
      n_total++; if (last_off != 8 || nvalid != 5) $display("FAIL single_span: got last T+%0d n=%0d want T+8 n=5", last_off, nvalid); else n_pass++;
      foreach (got_q[i]) begin
         n_total++;
         if (exp_q.size() == 0) $display("FAIL single_word%0d: got %h want nothing", i, got_q[i]);
         else begin
            e = exp_q.pop_front();
            if (got_q[i] !== e) $display("FAIL single_word%0d: got %h want %h", i, got_q[i], e); else n_pass++;
         end
      end
   endtask

   task automatic test_overflow();
      logic [63:0] e;
      for (int i = 1; i <= 7; i++)
         send_rec({16'(i), 16'(i), 16'(i + 10), 16'(i + 10)}, i == 1, i == 7, 1);
      n_total++; if (overflow !== ovf_m) $display("FAIL ovf_set: got %b want %b", overflow, ovf_m); else n_pass++;
      frame_capture();
      n_total++; if (nvalid != 5) $display("FAIL ovf_count: got %0d want 5", nvalid); else n_pass++;
      foreach (got_q[i]) begin
         n_total++;
         if (exp_q.size() == 0) $display("FAIL ovf_word%0d: got %h want nothing", i, got_q[i]);
         else begin
            e = exp_q.pop_front();
            if (got_q[i] !== e) $display("FAIL ovf_word%0d: got %h want %h", i, got_q[i], e); else n_pass++;
         end
      end
      det_start = 1'b1; stage_m.delete(); ovf_m = 0;
      @(posedge clk); #1; det_start = 1'b0;
      n_total++; if (overflow !== ovf_m) $display("FAIL ovf_clear: got %b want %b", overflow, ovf_m); else n_pass++;
   endtask

   task automatic test_discard();
      logic [63:0] e;
      send_rec({16'd48, 16'd96, 16'd10, 16'd100}, 1, 0, 1);
      send_rec({16'd48, 16'd96, 16'd60, 16'd100}, 0, 1, 1);
      frame_capture();
      n_total++; if (nvalid != 5) $display("FAIL discard_count: got %0d want 5", nvalid); else n_pass++;
      foreach (got_q[i]) begin
         n_total++;
         if (exp_q.size() == 0) $display("FAIL discard_word%0d: got %h want nothing", i, got_q[i]);
         else begin
            e = exp_q.pop_front();
            if (got_q[i] !== e) $display("FAIL discard_word%0d: got %h want %h", i, got_q[i], e); else n_pass++;
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] e;
      send_rec({16'd700, 16'd500, 16'd900, 16'd600}, 1, 1, 0);
      frame_capture();
      n_total++; if (first_off != 4 || last_off != 8) $display("FAIL b2b_span: got T+%0d..T+%0d want T+4..T+8", first_off, last_off); else n_pass++;
      n_total++; if (rdy_low != 5) $display("FAIL b2b_ready_low: got %0d cycles want 5", rdy_low); else n_pass++;
      foreach (got_q[i]) begin
         n_total++;
         if (exp_q.size() == 0) $display("FAIL b2b_word%0d: got %h want nothing", i, got_q[i]);
         else begin
            e = exp_q.pop_front();
            if (got_q[i] !== e) $display("FAIL b2b_word%0d: got %h want %h", i, got_q[i], e); else n_pass++;
         end
      end
      frame_capture();
      n_total++; if (nvalid != 0) $display("FAIL b2b_resync: got %0d words want 0", nvalid); else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      int seen = 0, late = 0;
      send_rec({16'd1, 16'd2, 16'd3, 16'd4}, 1, 1, 1);
      frame_sync = 1'b1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (bbox_data_out_valid) seen++;
         if (seen == 2) break;
         @(posedge clk); #1; frame_sync = 1'b0;
      end
      n_total++; if (seen != 2) $display("FAIL midrst_pre: got %0d words want 2", seen); else n_pass++;
      rstn = 1'b0; stage_m.delete(); pend_m.delete(); pend_vld_m = 0; ovf_m = 0;
      #1;
      n_total++; if (bbox_data_out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", bbox_data_out_valid); else n_pass++;
      repeat (2) @(posedge clk); #1; rstn = 1'b1;
      repeat (20) begin @(negedge clk); if (bbox_data_out_valid) late++; end
      n_total++; if (late != 0) $display("FAIL midrst_after: got %0d words want 0", late); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_no_commit();
      test_single();
      test_overflow();
      test_discard();
      test_back_to_back();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
